rv_serializer: RTL

Ready/valid width downsizer: accepts one IN_BYTES-wide word per handshake on the ingress port and emits it as IN_BYTES consecutive 8-bit beats on the egress port, least-significant byte first. It is the narrowing counterpart of the byte-stream path through the skid buffer. It sits where a wide datapath word has to leave on the 8-bit ready/valid streams used throughout the design. It sustains one byte per clock with no bubble between words.

---
 rtl/rv_pkg.sv | 12 +
 rtl/rv_serializer.sv | 92 +++++++++
 2 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the ready/valid byte-stream blocks: byte width and
// the serializer state encoding.
package rv_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } rv_ser_state_t;

endpackage

// File: rtl/rv_serializer.sv
// Ready/valid width downsizer: one IN_BYTES-wide word in, IN_BYTES bytes out, LSB first.
// Define RV_SERIALIZER_LAST_EN to add the e_last end-of-word flag.
module rv_serializer
  import rv_pkg::*;
#(
  parameter int IN_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [IN_BYTES*BYTE_W-1:0] i_data,
  output logic                       e_valid,
  input  logic                       e_ready,
  output logic [BYTE_W-1:0]          e_data
`ifdef RV_SERIALIZER_LAST_EN
  ,
  output logic                       e_last
`endif
);

  localparam int                CNT_W    = $clog2(IN_BYTES);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(IN_BYTES - 1);

  rv_ser_state_t                     state;
  logic [CNT_W-1:0]                  cnt;
  logic [IN_BYTES-1:0][BYTE_W-1:0]   word;
  logic                              last_beat;
  logic                              load;

  assign last_beat = (cnt == LAST_IDX);
  assign load      = i_valid & i_ready;

  // e_ready -> i_ready is combinational on purpose: it lets the next word load
  // in the same cycle the last byte leaves, so there is no bubble between words.
  always_comb begin
    // NOTE: default assignment first so no path leaves i_ready unassigned (no latch).
    i_ready = 1'b0;
    if (!rst) begin
      i_ready = (state == EMPTY) | ((state == BUSY) & last_beat & e_ready);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      cnt   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (i_valid) begin
            state <= BUSY;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (e_ready) begin
            if (!last_beat) begin
              cnt <= cnt + 1'b1;
            end else if (i_valid) begin
              cnt <= '0;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: begin
          state <= EMPTY;
          cnt   <= '0;
        end
      endcase
    end
  end

  // NOTE: the word register is datapath storage and is deliberately not reset;
  // it is only ever observed while state==BUSY, which implies it was loaded.
  always_ff @(posedge clk) begin
    if (load) begin
      word <= i_data;
    end
  end

  assign e_valid = (state == BUSY);
  assign e_data  = word[cnt];

`ifdef RV_SERIALIZER_LAST_EN
  assign e_last = e_valid & last_beat;
`endif

endmodule
